// File: rtl/gamepad_reader.sv
// Serial latch/clock gamepad front end: one read of a shift-register pad per poll.
// Optional GAMEPAD_DEBOUNCE_EN: publish buttons only after two identical consecutive reads.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for poll
// LATCH    | pad_latch high, pad parallel-loads its buttons
// SHIFT_LO | pad_clk low; synchronized bit sampled in the last cycle
// SHIFT_HI | pad_clk high; rising edge makes the pad present next bit
// DONE     | one cycle, valid pulses when buttons are updated
module gamepad_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_PERIOD  = 150,
  parameter int BIT_COUNT    = 16,
  parameter int BUTTON_COUNT = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    poll,
  input  logic                    pad_data,
  output logic                    pad_latch,
  output logic                    pad_clk,
  output logic [BUTTON_COUNT-1:0] buttons,
  output logic                    valid,
  output logic                    busy
);

  localparam int MAX_CYC = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4:0]              idx_q, idx_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic [BUTTON_COUNT-1:0] scan_q, scan_d;
  logic [BUTTON_COUNT-1:0] buttons_q, buttons_d;
  logic                    latch_q, latch_d;
  logic                    pclk_q, pclk_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
`ifdef GAMEPAD_DEBOUNCE_EN
  logic [BUTTON_COUNT-1:0] prev_q, prev_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sync1_d   = pad_data;
    sync2_d   = sync1_q;
    scan_d    = scan_q;
    buttons_d = buttons_q;
    latch_d   = latch_q;
    pclk_d    = pclk_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
`ifdef GAMEPAD_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (poll) begin
          state_d = S_LATCH;
          cnt_d   = CW'(LATCH_CYCLES - 1);
          latch_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT_LO;
          cnt_d   = CW'(HALF_PERIOD - 1);
          idx_d   = 5'd0;
          latch_d = 1'b0;
          pclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHIFT_LO: begin
        if (cnt_q == '0) begin
          // pad bits are active-low; bits beyond BUTTON_COUNT are dropped here
          for (int i = 0; i < BUTTON_COUNT; i++) begin
            if (idx_q == 5'(i)) scan_d[i] = ~sync2_q;
          end
          state_d = S_SHIFT_HI;
          cnt_d   = CW'(HALF_PERIOD - 1);
          pclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHIFT_HI: begin
        if (cnt_q == '0) begin
          if (idx_q == 5'(BIT_COUNT - 1)) begin
            state_d = S_DONE;
`ifdef GAMEPAD_DEBOUNCE_EN
            prev_d = scan_q;
            if (scan_q == prev_q) begin
              buttons_d = scan_q;
              valid_d   = 1'b1;
            end
`else
            buttons_d = scan_q;
            valid_d   = 1'b1;
`endif
          end else begin
            state_d = S_SHIFT_LO;
            idx_d   = idx_q + 5'd1;
            cnt_d   = CW'(HALF_PERIOD - 1);
            pclk_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        latch_d = 1'b0;
        pclk_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      scan_q    <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef GAMEPAD_DEBOUNCE_EN
      prev_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      scan_q    <= scan_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef GAMEPAD_DEBOUNCE_EN
      prev_q    <= prev_d;
`endif
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: behavioural pad, valid/buttons scoreboard, directed reads.
module tb_gamepad_reader;

  localparam int LAT  = 4;
  localparam int HALF = 4;
  localparam int BITS = 16;
  localparam int BTN  = 12;
  localparam int VALID_OFS = LAT + 2 * HALF * BITS;  // edges from poll edge to DONE cycle

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            poll = 1'b0;
  logic            pad_data;
  logic            pad_latch;
  logic            pad_clk;
  logic [BTN-1:0]  buttons;
  logic            valid;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [BTN-1:0] btn;
    int             cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sr = 16'hFFFF;

  gamepad_reader #(
    .LATCH_CYCLES(LAT),
    .HALF_PERIOD (HALF),
    .BIT_COUNT   (BITS),
    .BUTTON_COUNT(BTN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .poll     (poll),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // pad: parallel load while latched, shift toward bit 0 on pad_clk rise
  always @(posedge pad_clk) if (!pad_latch) pad_sr = {1'b1, pad_sr[15:1]};
  always @(pad_latch or pad_word) if (pad_latch) pad_sr = pad_word;
  assign pad_data = pad_sr[0];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_buttons", int'(buttons), int'(e.btn));
        chk("valid_cycle", edge_cnt, e.cyc);
      end
    end
  end

  task automatic do_read(input logic [15:0] word, input logic [BTN-1:0] exp_btn,
                         input bit exp_valid, input bit extra_polls);
    int k, lat, falls, t, seen;
    logic prev_clk;
    pad_word = word;
    @(negedge clk); poll = 1'b1;
    @(negedge clk); poll = 1'b0;
    k = edge_cnt;
    if (exp_valid) exp_q.push_back('{btn: exp_btn, cyc: k + VALID_OFS});
    chk("busy_rise", int'(busy), 1);
    lat = 0; falls = 0; t = 0; prev_clk = pad_clk;
    while (busy && t < 400) begin
      if (pad_latch) lat++;
      if (prev_clk && !pad_clk) falls++;
      prev_clk = pad_clk;
      poll = extra_polls && (edge_cnt == k + 9 || edge_cnt == k + 131 || edge_cnt == k + 132);
      @(negedge clk);
      t++;
    end
    poll = 1'b0;
    chk("read_timeout", int'(t < 400), 1);
    chk("latch_cycles", lat, LAT);
    chk("pad_clk_falls", falls, BITS);
    chk("busy_fall_cycle", edge_cnt, k + VALID_OFS + 1);
    chk("buttons_after_read", int'(buttons), int'(exp_btn));
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || pad_latch) seen = 1;
    end
    chk("no_restart", seen, 0);
  endtask

  initial begin
    int k;
    // reset held, poll pulsed inside reset
    repeat (2) @(negedge clk);
    poll = 1'b1;
    @(negedge clk);
    poll = 1'b0;
    @(negedge clk);
    chk("rst_pad_latch", int'(pad_latch), 0);
    chk("rst_pad_clk", int'(pad_clk), 1);
    chk("rst_buttons", int'(buttons), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(busy | pad_latch), 0);

    // idle pad -> nothing pressed
    do_read(16'hFFFF, 12'h000, 1'b1, 1'b0);
`ifdef GAMEPAD_DEBOUNCE_EN
    do_read(16'h07DE, 12'h000, 1'b0, 1'b0);
`else
    do_read(16'h07DE, 12'h821, 1'b1, 1'b0);
`endif
    // same pattern again, with polls during the read and in DONE
    do_read(16'h07DE, 12'h821, 1'b1, 1'b1);

    // reset mid-read while pad_clk is low
    pad_word = 16'h0000;
    @(negedge clk); poll = 1'b1;
    @(negedge clk); poll = 1'b0;
    k = edge_cnt;
    while (edge_cnt < k + 53) @(negedge clk);
    chk("pre_rst_pad_clk_low", int'(pad_clk), 0);
    chk("pre_rst_buttons", int'(buttons), 12'h821);
    reset = 1'b0;
    #1;
    chk("mid_rst_pad_latch", int'(pad_latch), 0);
    chk("mid_rst_pad_clk", int'(pad_clk), 1);
    chk("mid_rst_buttons", int'(buttons), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_mid_rst_idle", int'(busy | pad_latch), 0);
    do_read(16'hFFFF, 12'h000, 1'b1, 1'b0);

    // reads returning 021, 021, 003
`ifdef GAMEPAD_DEBOUNCE_EN
    do_read(16'hFFDE, 12'h000, 1'b0, 1'b0);
    do_read(16'hFFDE, 12'h021, 1'b1, 1'b0);
    do_read(16'hFFFC, 12'h021, 1'b0, 1'b0);
`else
    do_read(16'hFFDE, 12'h021, 1'b1, 1'b0);
    do_read(16'hFFDE, 12'h021, 1'b1, 1'b0);
    do_read(16'hFFFC, 12'h003, 1'b1, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
